// File: rtl/riscv_pkg.sv
// Shared store-path definitions: funct3 store encodings, store FSM states,
// and the byte-lane mask helper used by the lane aligner.
package riscv_pkg;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;
  localparam logic [2:0] STORE_SD = 3'b011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } store_state_t;

  // Byte-lane mask for a store anchored at lane 0; reserved encodings
  // (funct3[2] set) enable no lanes at all.
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    logic [7:0] m;
    m = 8'h00;
    if (!funct3[2]) begin
      case (funct3[1:0])
        2'b00:   m = 8'h01;
        2'b01:   m = 8'h03;
        2'b10:   m = 8'h0f;
        default: m = 8'hff;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane aligner: places store data and byte strobes on the
// memory lanes for either beat of a (possibly word-crossing) store, and
// classifies the access as crossing and/or misaligned.
module store_lane_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFS = $clog2(BYTES)
) (
  input  logic [OFS-1:0]   offset,
  input  logic [XLEN-1:0]  data,
  input  logic [2:0]       funct3,
  input  logic             beat,
  output logic [XLEN-1:0]  wdata,
  output logic [BYTES-1:0] wstrb,
  output logic             crossing,
  output logic             misaligned
);

  logic [7:0]        mask8;
  logic [15:0]       strb_wide;
  logic [XLEN-1:0]   data_masked;
  logic [2*XLEN-1:0] data_wide;
  logic [OFS-1:0]    amask;

  assign mask8 = size_mask(funct3);

  // Drop bytes above the access size so stale upper bytes of rs2 never
  // reach memory, even on lanes whose strobe is clear.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign data_masked[8*gi +: 8] = data[8*gi +: 8] & {8{mask8[gi]}};
    end
  endgenerate

  // Double-width shifts: the low half is beat 0, the high half is what
  // spills into the next aligned word (beat 1).
  assign strb_wide = {8'h00, mask8} << offset;
  assign data_wide = {{XLEN{1'b0}}, data_masked} << {offset, 3'b000};

  // Any enabled lane past the top of the word means the store crosses.
  assign crossing = |strb_wide[15:BYTES];

  // Natural alignment requires the offset to be a multiple of the size.
  assign amask      = OFS'((4'd1 << funct3[1:0]) - 4'd1);
  assign misaligned = |(offset & amask);

  assign wstrb = beat ? strb_wide[2*BYTES-1:BYTES] : strb_wide[BYTES-1:0];
  assign wdata = beat ? data_wide[2*XLEN-1:XLEN]   : data_wide[XLEN-1:0];

endmodule

// File: rtl/store_unit.sv
// Store unit between the core's MEMWRITE stage and data memory. Accepts one
// sb/sh/sw(/sd) request, issues one or two aligned write beats on a
// valid/ready port, and reports completion or fault with a done pulse.
module store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1,
  localparam int BYTES = XLEN / 8,
  localparam int OFS = $clog2(BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_data,
  input  logic [2:0]       req_funct3,
  output logic             done_valid,
  output logic             done_fault,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [BYTES-1:0] mem_wstrb,
  output logic             busy
);

  store_state_t state;

  // Request fields captured at accept; only beat 1 needs them later.
  logic [OFS-1:0]  offset_reg;
  logic [XLEN-1:0] data_reg;
  logic [2:0]      funct3_reg;
  logic            crossing_reg;

  logic            idle;
  logic [OFS-1:0]  al_offset;
  logic [XLEN-1:0] al_data;
  logic [2:0]      al_funct3;
  logic [XLEN-1:0] al_wdata;
  logic [BYTES-1:0] al_wstrb;
  logic            al_crossing;
  logic            al_misaligned;
  logic            illegal;
  logic            unsupported;

  assign idle = (state == IDLE);

  // Held low throughout reset; otherwise tracks the idle state directly.
  assign req_ready = idle & reset;

  // One aligner serves both beats: in IDLE it looks at the live request to
  // prepare beat 0, afterwards at the captured request to prepare beat 1.
  assign al_offset = idle ? req_addr[OFS-1:0] : offset_reg;
  assign al_data   = idle ? req_data          : data_reg;
  assign al_funct3 = idle ? req_funct3        : funct3_reg;

  store_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .offset    (al_offset),
    .data      (al_data),
    .funct3    (al_funct3),
    .beat      (~idle),
    .wdata     (al_wdata),
    .wstrb     (al_wstrb),
    .crossing  (al_crossing),
    .misaligned(al_misaligned)
  );

  // Reserved encodings, and sd on a 32-bit datapath, are rejected outright.
  assign illegal = req_funct3[2] || ((XLEN == 32) && (req_funct3 == STORE_SD));

  // Without splitting, any misaligned or word-crossing store is refused.
  assign unsupported = !SPLIT_MISALIGNED && (al_misaligned || al_crossing);

  // Store FSM with registered memory-port and completion outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      offset_reg   <= '0;
      data_reg     <= '0;
      funct3_reg   <= '0;
      crossing_reg <= 1'b0;
      done_valid   <= 1'b0;
      done_fault   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            offset_reg   <= req_addr[OFS-1:0];
            data_reg     <= req_data;
            funct3_reg   <= req_funct3;
            crossing_reg <= al_crossing;
            busy         <= 1'b1;
            if (illegal || unsupported) begin
              state      <= FAULT;
              done_valid <= 1'b1;
              done_fault <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[XLEN-1:OFS], {OFS{1'b0}}};
              mem_wdata <= al_wdata;
              mem_wstrb <= al_wstrb;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (crossing_reg) begin
              state     <= BEAT1;
              mem_addr  <= mem_addr + XLEN'(BYTES);
              mem_wdata <= al_wdata;
              mem_wstrb <= al_wstrb;
            end else begin
              state      <= DONE;
              mem_valid  <= 1'b0;
              done_valid <= 1'b1;
              done_fault <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            state      <= DONE;
            mem_valid  <= 1'b0;
            done_valid <= 1'b1;
            done_fault <= 1'b0;
          end
        end
        DONE, FAULT: begin
          state      <= IDLE;
          done_valid <= 1'b0;
          done_fault <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mem_valid  <= 1'b0;
          done_valid <= 1'b0;
          done_fault <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Parametrised store path between the multicycle core's MEMWRITE stage and data memory; successor to the fixed word-only store path.
- Accepts one store request (address, data, funct3) and drives a valid/ready memory write port with byte strobes.
- Supports sb/sh/sw, plus sd when XLEN=64.
- Handles misaligned stores either by faulting or by splitting into two aligned beats; the core's control FSM waits on a done pulse instead of a fixed cycle count.

Parameters:
- XLEN, 32, data/address width in bits; 32 or 64 only. BYTES = XLEN/8, OFS = log2(BYTES).
- SPLIT_MISALIGNED, 1, 1 = split word-crossing stores into two beats; 0 = report fault, no memory access.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a store.
- req_ready  out  1  unit idle, can accept.
- req_addr  in  XLEN  byte address (rs1 + imm).
- req_data  in  XLEN  rs2 value, data in low bytes.
- req_funct3  in  3  000 sb, 001 sh, 010 sw, 011 sd.
- done_valid  out  1  one-cycle pulse, store finished.
- done_fault  out  1  qualifies done_valid; 1 = misaligned-unsupported or illegal funct3.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  XLEN  beat address, low OFS bits always zero.
- mem_wdata  out  XLEN  lane-aligned write data.
- mem_wstrb  out  BYTES  byte enables, bit i = byte lane i.
- busy  out  1  not IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE.
  - req_ready=1 once reset is released; while reset=0 all outputs are 0.
  - All other outputs 0 after reset, including mem_addr/mem_wdata/mem_wstrb.
- Accept occurs when req_valid & req_ready. Inputs are latched, so req_* may change afterwards. req_ready=0 outside IDLE.
- Size: SZ = 1 << funct3[1:0]; base mask = (1<<SZ)-1. off = addr[OFS-1:0].
- Illegal: funct3[2]=1, or funct3=011 with XLEN=32. Result: FAULT.
- Crossing: off + SZ > BYTES.
  - Crossing with SPLIT_MISALIGNED=0 goes to FAULT.
  - Any misalignment (off % SZ != 0) with SPLIT_MISALIGNED=0 also goes to FAULT.
- Beat0:
  - mem_addr = addr with low OFS bits cleared.
  - mem_wstrb = (mask << off) truncated to BYTES.
  - mem_wdata = req_data << 8*off.
- Beat1 (crossing only):
  - mem_addr = beat0 address + BYTES, wrapping modulo 2^XLEN.
  - mem_wstrb = mask >> (BYTES-off).
  - mem_wdata = req_data >> 8*(BYTES-off).
- FSM:
  - IDLE -> BEAT0 (legal), or -> FAULT (illegal/unsupported) on accept.
  - BEAT0: mem_valid=1; on mem_ready -> BEAT1 if crossing, else DONE.
  - BEAT1: mem_valid=1; on mem_ready -> DONE.
  - DONE: done_valid=1, done_fault=0, one cycle -> IDLE.
  - FAULT: done_valid=1, done_fault=1, one cycle -> IDLE; mem_valid never asserted.
- Latency:
  - Accept at edge N gives mem_valid high in cycle N+1.
  - Zero-wait memory gives done at N+2 for one beat, N+3 for two beats.
  - Fault gives done at N+1.
- Backpressure: while mem_valid=1 & mem_ready=0, mem_addr/wdata/wstrb are held constant. mem_valid never drops before the handshake.
- Outputs are registered, with no combinational path req_* -> mem_*. mem_ready -> state is the only combinational path into the next state.
- Reset mid-operation aborts immediately; no done pulse. If beat0 was already accepted, it stays committed in memory (documented non-atomic behaviour).
- No back-to-back accept: req_ready returns to 1 in the cycle after DONE/FAULT.

Decomposition:
- Package riscv_pkg holds:
  - funct3 constants STORE_SB/SH/SW/SD;
  - enum store_state_t {IDLE, BEAT0, BEAT1, DONE, FAULT};
  - function size_mask(funct3).
- Sub-module store_lane_align (purely combinational): inputs addr offset, data, funct3, beat index; outputs wdata, wstrb, crossing, misaligned.
- store_unit keeps the FSM and registers.

Test Plan:
- sw, data 0x00000100 at addr 44, mem_ready tied 1 -> one beat: mem_addr=44, wstrb=1111, wdata=0x00000100, done_valid at N+2, done_fault=0.
- sb, data 0xdeadbeef at addr 45 -> mem_addr=44, wstrb=0010, wdata=0x0000ef00.
- sh, data 0x0000abcd at addr 47, SPLIT=1:
  - beat0: addr 44, wstrb 1000, wdata 0xcd000000;
  - beat1: addr 48, wstrb 0001, wdata 0x000000ab;
  - done at N+3.
- sw at addr 46, SPLIT=0 -> done_valid+done_fault at N+1, mem_valid never 1. Repeat with funct3=011, XLEN=32 -> fault.
- mem_ready low 3 cycles during sw at 48 -> mem_valid/addr/wdata/wstrb stable all 3 cycles; done one cycle after the handshake.
- Reset asserted while BEAT1 waits -> mem_valid=0 and busy=0 asynchronously, no done pulse. After release, req_ready=1 and a new sw at 52 completes normally.
